// File: rtl/rst_seq.sv
// Reset sequencer: synchronises the clock-wizard lock and reset button, debounces the
// button, then releases N_CH reset channels in index order once lock has been stable.
module rst_seq #(
    parameter int N_CH        = 4,
    parameter int STRETCH     = 16,
    parameter int STAGGER     = 8,
    parameter int DEB_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            locked,
    input  logic            btn,
    output logic [N_CH-1:0] rst_out,
    output logic            all_released,
    output logic [7:0]      lock_lost_cnt
);

    localparam int CNT_MAX = (STRETCH > STAGGER) ? STRETCH : STAGGER;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

    // IDLE: all held | STRETCH: lock settling | RELEASE: staggered release | RUN: all released
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_STRETCH = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic                   locked_s;
    logic                   btn_s;

    logic                   btn_deb_q, btn_deb_d;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [N_CH-1:0]        rst_out_q, rst_out_d;
    logic                   all_rel_q, all_rel_d;
    logic [7:0]             lost_q, lost_d;
    logic                   abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= '0;
            btn_sync_q  <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked};
            btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    assign locked_s = lock_sync_q[SYNC_STAGES-1];
    assign btn_s    = btn_sync_q[SYNC_STAGES-1];

    always_comb begin
        btn_deb_d = btn_deb_q;
        deb_cnt_d = deb_cnt_q;
        if (btn_s == btn_deb_q) begin
            deb_cnt_d = '0;
        end else if (&deb_cnt_q) begin
            btn_deb_d = btn_s;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
    end

    assign abort = !locked_s || btn_deb_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        rst_out_d = rst_out_q;
        all_rel_d = all_rel_q;
        lost_d    = lost_q;
        if (state_q != ST_IDLE && abort) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            ch_d      = '0;
            rst_out_d = '1;
            all_rel_d = 1'b0;
            if (!locked_s && lost_q != 8'hFF) begin
                lost_d = lost_q + 8'd1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rst_out_d = '1;
                    all_rel_d = 1'b0;
                    if (!abort) begin
                        state_d = ST_STRETCH;
                        cnt_d   = '0;
                    end
                end
                ST_STRETCH: begin
                    if (cnt_q == CNT_W'(STRETCH - 1)) begin
                        cnt_d = '0;
                        if (N_CH == 1) begin
                            state_d   = ST_RUN;
                            rst_out_d = '0;
                            all_rel_d = 1'b1;
                        end else begin
                            state_d      = ST_RELEASE;
                            rst_out_d[0] = 1'b0;
                            ch_d         = CH_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CNT_W'(STAGGER - 1)) begin
                        cnt_d           = '0;
                        rst_out_d[ch_q] = 1'b0;
                        ch_d            = ch_q + CH_W'(1);
                        if (ch_q == CH_W'(N_CH - 1)) begin
                            state_d   = ST_RUN;
                            all_rel_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_deb_q <= 1'b0;
            deb_cnt_q <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            rst_out_q <= '1;
            all_rel_q <= 1'b0;
            lost_q    <= 8'd0;
        end else begin
            btn_deb_q <= btn_deb_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            rst_out_q <= rst_out_d;
            all_rel_q <= all_rel_d;
            lost_q    <= lost_d;
        end
    end

    assign rst_out       = rst_out_q;
    assign all_released  = all_rel_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: a timeline table, directed corner sequences and random lock/button
// activity, all checked against a cycle-level behavioural model of the release timing.
module tb_rst_seq;

    localparam int N_CH    = 4;
    localparam int STRETCH = 16;
    localparam int STAGGER = 8;
    localparam int DEB_W   = 4;
    localparam int SYNC    = 2;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b1;
    logic            locked = 1'b0;
    logic            btn    = 1'b0;
    logic [N_CH-1:0] rst_out;
    logic            all_released;
    logic [7:0]      lock_lost_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit mdl_chk_en = 1'b0;
    int exp_lost = 0;

    rst_seq #(
        .N_CH(N_CH), .STRETCH(STRETCH), .STAGGER(STAGGER),
        .DEB_W(DEB_W), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .btn(btn),
        .rst_out(rst_out), .all_released(all_released), .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_t counts edges since the sequence started; channel i is released
    // once m_t reaches STRETCH + i*STAGGER.
    bit lk_pipe[SYNC];
    bit bt_pipe[SYNC];
    bit m_bdeb, m_in_seq, m_lk_s, m_bt_s, m_ab;
    int m_run, m_t, m_lost;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) begin
                lk_pipe[i] = 1'b0;
                bt_pipe[i] = 1'b0;
            end
            m_bdeb = 0; m_run = 0; m_in_seq = 0; m_t = 0; m_lost = 0;
        end else begin
            m_lk_s = lk_pipe[SYNC-1];
            m_bt_s = bt_pipe[SYNC-1];
            m_ab   = !m_lk_s || m_bdeb;
            if (!m_in_seq) begin
                if (!m_ab) begin
                    m_in_seq = 1;
                    m_t = 0;
                end
            end else if (m_ab) begin
                m_in_seq = 0;
                if (!m_lk_s && m_lost < 255) m_lost++;
            end else if (m_t < 1000000) begin
                m_t++;
            end
            if (m_bt_s != m_bdeb) begin
                m_run++;
                if (m_run == (1 << DEB_W)) begin
                    m_bdeb = m_bt_s;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            for (int i = SYNC-1; i > 0; i--) begin
                lk_pipe[i] = lk_pipe[i-1];
                bt_pipe[i] = bt_pipe[i-1];
            end
            lk_pipe[0] = locked;
            bt_pipe[0] = btn;
        end
    end

    function automatic logic [N_CH-1:0] m_rst();
        logic [N_CH-1:0] r;
        for (int i = 0; i < N_CH; i++)
            r[i] = !(m_in_seq && m_t >= STRETCH + i*STAGGER);
        return r;
    endfunction

    always @(negedge clk) begin
        if (mdl_chk_en) begin
            chk("mdl_rst_out", rst_out, m_rst());
            chk("mdl_all_released", all_released,
                (m_in_seq && m_t >= STRETCH + (N_CH-1)*STAGGER) ? 1 : 0);
            chk("mdl_lock_lost_cnt", lock_lost_cnt, m_lost);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_all(input int max_cyc, input string name);
        int k = 0;
        while (all_released !== 1'b1 && k < max_cyc) begin
            step(1);
            k++;
        end
        chk(name, all_released, 1);
    endtask

    task automatic wait_rst(input logic [N_CH-1:0] val, input int max_cyc, input string name);
        int k = 0;
        while (rst_out !== val && k < max_cyc) begin
            step(1);
            k++;
        end
        chk(name, rst_out, val);
    endtask

    typedef struct {
        int              edge_n;
        bit              lk;
        bit              bt;
        logic [N_CH-1:0] exp_rst;
        bit              exp_all;
        int              exp_lost;
    } vec_t;

    vec_t vecs[15];
    int   cur_edge;
    int   lost_before;

    initial begin
        vecs[0]  = '{18,  1, 0, 4'hF, 0, 0};
        vecs[1]  = '{19,  1, 0, 4'hE, 0, 0};
        vecs[2]  = '{26,  1, 0, 4'hE, 0, 0};
        vecs[3]  = '{27,  1, 0, 4'hC, 0, 0};
        vecs[4]  = '{34,  1, 0, 4'hC, 0, 0};
        vecs[5]  = '{35,  1, 0, 4'h8, 0, 0};
        vecs[6]  = '{42,  1, 0, 4'h8, 0, 0};
        vecs[7]  = '{43,  1, 0, 4'h0, 1, 0};
        vecs[8]  = '{60,  1, 0, 4'h0, 1, 0};
        vecs[9]  = '{62,  0, 0, 4'h0, 1, 0};
        vecs[10] = '{63,  0, 0, 4'hF, 0, 1};
        vecs[11] = '{81,  1, 0, 4'hF, 0, 1};
        vecs[12] = '{82,  1, 0, 4'hE, 0, 1};
        vecs[13] = '{105, 1, 0, 4'h8, 0, 1};
        vecs[14] = '{106, 1, 0, 4'h0, 1, 1};

        locked = 1'b1;
        btn    = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rst_out", rst_out, 4'hF);
        chk("reset_all_released", all_released, 0);
        chk("reset_lost", lock_lost_cnt, 0);
        mdl_chk_en = 1'b1;
        rst_n = 1'b1;

        // power-up timeline, edges counted from reset release
        cur_edge = 0;
        for (int v = 0; v < 15; v++) begin
            locked = vecs[v].lk;
            btn    = vecs[v].bt;
            step(vecs[v].edge_n - cur_edge);
            cur_edge = vecs[v].edge_n;
            chk($sformatf("tbl%0d_rst_out", v), rst_out, vecs[v].exp_rst);
            chk($sformatf("tbl%0d_all_rel", v), all_released, vecs[v].exp_all);
            chk($sformatf("tbl%0d_lost", v), lock_lost_cnt, vecs[v].exp_lost);
        end
        exp_lost = 1;

        // single-cycle lock drop in RUN
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(2);
        exp_lost++;
        chk("glitch_rst_out", rst_out, 4'hF);
        chk("glitch_all_rel", all_released, 0);
        chk("glitch_lost", lock_lost_cnt, exp_lost);
        step(40);
        chk("glitch_rerun_pre", rst_out, 4'h8);
        step(1);
        chk("glitch_rerun_rst", rst_out, 4'h0);
        chk("glitch_rerun_all", all_released, 1);

        // short button pulse mid-RELEASE, then a long hold
        locked = 1'b0;
        step(4);
        exp_lost++;
        locked = 1'b1;
        wait_rst(4'hC, 60, "btn_reach_release");
        lost_before = exp_lost;
        btn = 1'b1;
        step(10);
        btn = 1'b0;
        wait_all(60, "btn_short_completes");
        chk("btn_short_rst", rst_out, 4'h0);
        chk("btn_short_lost", lock_lost_cnt, lost_before);
        step(5);
        btn = 1'b1;
        step(18);
        chk("btn_hold_pre_abort", all_released, 1);
        step(1);
        chk("btn_hold_rst", rst_out, 4'hF);
        chk("btn_hold_all", all_released, 0);
        chk("btn_hold_lost", lock_lost_cnt, lost_before);
        step(21);
        btn = 1'b0;
        wait_all(120, "btn_hold_recover");

        // lock loss and debounced button together, repeated to saturation
        for (int it = 0; it < 300; it++) begin
            btn = 1'b1;
            step(16);
            locked = 1'b0;
            step(2);
            if (it == 0) chk("both_pre_abort", all_released, 1);
            step(1);
            exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
            if (it == 0) begin
                chk("both_rst", rst_out, 4'hF);
                chk("both_lost_once", lock_lost_cnt, exp_lost);
                step(3);
                chk("both_lost_single", lock_lost_cnt, exp_lost);
            end
            btn = 1'b0;
            locked = 1'b1;
            wait_all(150, "both_rerun");
        end
        chk("sat_lost", lock_lost_cnt, 255);

        // asynchronous reset mid-STRETCH and mid-RELEASE
        locked = 1'b0;
        step(4);
        locked = 1'b1;
        step(11);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stretch_rst", rst_out, 4'hF);
        chk("arst_stretch_lost", lock_lost_cnt, 0);
        chk("arst_stretch_all", all_released, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_lost = 0;
        step(18);
        chk("arst_restart_pre", rst_out, 4'hF);
        step(1);
        chk("arst_restart_ch0", rst_out, 4'hE);
        step(10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_release_rst", rst_out, 4'hF);
        chk("arst_release_lost", lock_lost_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(42);
        chk("arst_rerun_pre", all_released, 0);
        step(1);
        chk("arst_rerun_all", all_released, 1);
        chk("arst_rerun_rst", rst_out, 4'h0);

        // lock toggling faster than STRETCH never releases anything
        locked = 1'b0;
        step(5);
        for (int k = 0; k < 20; k++) begin
            locked = ~locked;
            for (int c = 0; c < 5; c++) begin
                step(1);
                chk("toggle_rst", rst_out, 4'hF);
                chk("toggle_all", all_released, 0);
            end
        end

        // random lock/button activity
        for (int s = 0; s < 80; s++) begin
            locked = ($urandom_range(0, 5) != 0);
            btn    = ($urandom_range(0, 6) == 0);
            step($urandom_range(1, 70));
        end
        locked = 1'b1;
        btn = 1'b0;
        step(80);

        mdl_chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
